// File: rtl/sram_test_pkg.sv
// Shared types and helpers for the SRAM pattern tester.
//   state_t       : controller states
//   PAT_*         : pattern_sel codes
//   pattern_value : expected word for (addr, seed, sel); result is wide and
//                   truncated by the caller to its data width.
package sram_test_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_TURN,
    S_R_ADDR, S_R_WAIT, S_R_CHECK, S_DONE
  } state_t;

  localparam logic [1:0] PAT_INCR  = 2'd0;
  localparam logic [1:0] PAT_FOLD  = 2'd1;
  localparam logic [1:0] PAT_WALK  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam int MAX_W = 64;

  // aw/dw are the caller's address/data widths (elaboration constants).
  function automatic logic [MAX_W-1:0] pattern_value(
    input logic [MAX_W-1:0] addr,
    input logic [15:0]      seed,
    input logic [1:0]       sel,
    input int               aw,
    input int               dw
  );
    logic [MAX_W-1:0] r;
    r = '0;
    case (sel)
      PAT_INCR: r = addr + MAX_W'(seed);
      // XOR every dw-wide slice of the address together
      PAT_FOLD: begin
        for (int i = 0; i < MAX_W; i++)
          if (i < aw) r[i % dw] = r[i % dw] ^ addr[i];
      end
      PAT_WALK: r = MAX_W'(1) << ((addr + MAX_W'(seed)) % MAX_W'(dw));
      // 0x55.. when addr[0]^seed[0] is 0, otherwise 0xAA..
      default: begin
        for (int i = 0; i < MAX_W; i++)
          r[i] = ((i % 2) == 0) ^ addr[0] ^ seed[0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_pattern_gen.sv
// Registered expected-data generator.
//   addr/seed/sel : next-cycle address, seed and pattern of the controller
//   value         : pattern word aligned with the controller's registered addr
// Fed with next-state values so the word is ready in the same cycle the
// address appears, keeping the pattern math off the compare path.
module sram_pattern_gen #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       seed,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] value
);
  import sram_test_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else     value <= DATA_W'(pattern_value(MAX_W'(addr), seed, sel, ADDR_W, DATA_W));
  end

endmodule

// File: rtl/sram_pattern_tester.sv
// SRAM built-in self test: write a pattern over 0..ADDR_LAST, read it back,
// count mismatches and hold the first failing location.
//   clk, rst (sync, active high), start, pattern_sel, loop : control
//   busy, done, pass, err_count, pass_count, fail_*         : status
//   sram_addr, sram_data, sram_cs/oe/we (active low)        : SRAM pins
module sram_pattern_tester #(
  parameter int              ADDR_W    = 18,
  parameter int              DATA_W    = 16,
  parameter logic [ADDR_W-1:0] ADDR_LAST = '1,
  parameter int              WE_CYCLES = 1,
  parameter int              RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic              loop,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       pass_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we
);
  import sram_test_pkg::*;

  localparam int CNT_MAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [15:0]       seed, seed_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] exp_data, rdata;
  logic [15:0]       err_d;
  logic              drive, run_start, pass_end, mismatch, rd_latch;

  sram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gen (
    .clk(clk), .rst(rst), .addr(addr_d), .seed(seed_d), .sel(sel_d), .value(exp_data)
  );

  assign sram_addr = addr;
  assign sram_data = drive ? exp_data : 'z;

  assign rd_latch = (state == S_R_WAIT) && (cnt == CNT_W'(RD_CYCLES - 1));
  assign mismatch = (state == S_R_CHECK) && (rdata != exp_data);
  assign pass_end = (state == S_R_CHECK) && (addr == ADDR_LAST);

  always_comb begin
    state_d   = state;
    addr_d    = addr;
    seed_d    = seed;
    sel_d     = sel_q;
    cnt_d     = cnt;
    run_start = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        run_start = 1'b1;
        addr_d    = '0;
        seed_d    = '0;
        sel_d     = pattern_sel;
        state_d   = S_W_SETUP;
      end
      S_W_SETUP: begin
        cnt_d   = '0;
        state_d = S_W_PULSE;
      end
      S_W_PULSE: begin
        if (cnt == CNT_W'(WE_CYCLES - 1)) state_d = S_W_HOLD;
        else                              cnt_d   = cnt + 1'b1;
      end
      S_W_HOLD: begin
        if (addr == ADDR_LAST) state_d = S_TURN;
        else begin
          addr_d  = addr + 1'b1;
          state_d = S_W_SETUP;
        end
      end
      S_TURN: begin
        addr_d  = '0;
        state_d = S_R_ADDR;
      end
      S_R_ADDR: begin
        cnt_d   = '0;
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (rd_latch) state_d = S_R_CHECK;
        else          cnt_d   = cnt + 1'b1;
      end
      S_R_CHECK: begin
        if (addr != ADDR_LAST) begin
          addr_d  = addr + 1'b1;
          state_d = S_R_ADDR;
        end else if (loop) begin
          seed_d  = seed + 1'b1;
          addr_d  = '0;
          sel_d   = pattern_sel;
          state_d = S_W_SETUP;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // error count after this edge; pass is derived from it so it stays registered
  always_comb begin
    err_d = err_count;
    if (run_start)                         err_d = '0;
    else if (mismatch && err_count != '1)  err_d = err_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      seed       <= '0;
      sel_q      <= '0;
      cnt        <= '0;
      rdata      <= '0;
      err_count  <= '0;
      pass_count <= '0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      sram_cs    <= 1'b1;
      sram_oe    <= 1'b1;
      sram_we    <= 1'b1;
      drive      <= 1'b0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      seed      <= seed_d;
      sel_q     <= sel_d;
      cnt       <= cnt_d;
      err_count <= err_d;
      if (rd_latch) rdata <= sram_data;
      if (run_start) begin
        pass_count <= '0;
        fail_addr  <= '0;
        fail_exp   <= '0;
        fail_got   <= '0;
      end else begin
        if (mismatch && err_count == '0) begin
          fail_addr <= addr;
          fail_exp  <= exp_data;
          fail_got  <= rdata;
        end
        if (pass_end) pass_count <= pass_count + 1'b1;
      end
      // strobes decoded from the next state so every pin is a flop
      busy    <= (state_d != S_IDLE) && (state_d != S_DONE);
      done    <= (state_d == S_DONE);
      pass    <= (state_d == S_DONE) && (err_d == '0);
      sram_cs <= (state_d == S_IDLE) || (state_d == S_DONE);
      sram_oe <= !((state_d == S_R_ADDR) || (state_d == S_R_WAIT) || (state_d == S_R_CHECK));
      sram_we <= (state_d != S_W_PULSE);
      drive   <= (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_HOLD);
    end
  end

endmodule
